// File: rtl/lif_pkg.sv
// Shared encodings and helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

  localparam logic MODE_RESET    = 1'b0;
  localparam logic MODE_SUBTRACT = 1'b1;

  // Unsigned add of two operands of up to 16 bits, clipped to 2^width-1.
  function automatic logic [15:0] sat_add(logic [15:0] a, logic [15:0] b, int unsigned width);
    logic [16:0] full;
    logic [16:0] max_val;
    full    = {1'b0, a} + {1'b0, b};
    max_val = (17'd1 << width) - 17'd1;
    return (full > max_val) ? 16'(max_val) : 16'(full);
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron leak/integrate/fire step shared by all neurons.
module lif_update
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LEAK_SHIFT    = 3,
  parameter int unsigned REFRAC_SWEEPS = 2,
  parameter int unsigned RW            = 2
) (
  input  logic [WIDTH-1:0] state,
  input  logic [RW-1:0]    refrac,
  input  logic [WIDTH-1:0] stim,
  input  logic [WIDTH-1:0] threshold,
  input  logic             mode,
  output logic [WIDTH-1:0] state_next,
  output logic [RW-1:0]    refrac_next,
  output logic             spike
);

  logic [WIDTH-1:0] leaked;
  logic [15:0]      sat_full;
  logic [WIDTH-1:0] sum;

  always_comb begin
    state_next  = '0;
    refrac_next = refrac;
    spike       = 1'b0;
    // Leak never underflows: s >> k <= s.
    leaked      = state - (state >> LEAK_SHIFT);
    sat_full    = sat_add(16'(leaked), 16'(stim), WIDTH);
    sum         = WIDTH'(sat_full);
    if (refrac != '0) begin
      refrac_next = refrac - RW'(1);
    end else if (sum >= threshold) begin
      spike       = 1'b1;
      refrac_next = RW'(REFRAC_SWEEPS);
      state_next  = (mode == MODE_SUBTRACT) ? sum - threshold : '0;
    end else begin
      state_next = sum;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Round-robin array of LIF neurons: one shared datapath updates neuron ptr per enabled clock.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned N_NEURONS     = 4,
  parameter int unsigned LEAK_SHIFT    = 3,
  parameter int unsigned REFRAC_SWEEPS = 2,
  localparam int unsigned IW           = $clog2(N_NEURONS),
  localparam int unsigned RW           = cnt_width(REFRAC_SWEEPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           threshold,
  input  logic [N_NEURONS*WIDTH-1:0] stim_current,
  input  logic [IW-1:0]              sel,
  output logic [N_NEURONS-1:0]       spike,
  output logic [WIDTH-1:0]           state_out,
  output logic [IW-1:0]              active_idx,
  output logic                       sweep_done
);

  logic [WIDTH-1:0]     state_q  [N_NEURONS];
  logic [RW-1:0]        refrac_q [N_NEURONS];
  logic [N_NEURONS-1:0] spike_q;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 sweep_q;
  logic                 last_slot;

  logic [WIDTH-1:0] cur_state, cur_stim, upd_state;
  logic [RW-1:0]    cur_refrac, upd_refrac;
  logic             upd_spike;

  always_comb begin
    cur_state  = '0;
    cur_refrac = '0;
    cur_stim   = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (ptr_q == IW'(i)) begin
        cur_state  = state_q[i];
        cur_refrac = refrac_q[i];
        cur_stim   = stim_current[i*WIDTH +: WIDTH];
      end
    end
    last_slot = (ptr_q == IW'(N_NEURONS - 1));
    ptr_d     = last_slot ? '0 : ptr_q + IW'(1);
  end

  lif_update #(
    .WIDTH        (WIDTH),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .REFRAC_SWEEPS(REFRAC_SWEEPS),
    .RW           (RW)
  ) u_update (
    .state      (cur_state),
    .refrac     (cur_refrac),
    .stim       (cur_stim),
    .threshold  (threshold),
    .mode       (mode),
    .state_next (upd_state),
    .refrac_next(upd_refrac),
    .spike      (upd_spike)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i]  <= '0;
        refrac_q[i] <= '0;
      end
      spike_q <= '0;
      ptr_q   <= '0;
      sweep_q <= 1'b0;
    end else begin
      sweep_q <= enable && last_slot;
      if (enable) begin
        for (int i = 0; i < N_NEURONS; i++) begin
          if (ptr_q == IW'(i)) begin
            state_q[i]  <= upd_state;
            refrac_q[i] <= upd_refrac;
            spike_q[i]  <= upd_spike;
          end
        end
        ptr_q <= ptr_d;
      end
    end
  end

  // Debug mux; selectors past the last neuron read as zero.
  always_comb begin
    state_out = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (sel == IW'(i)) state_out = state_q[i];
    end
  end

  assign spike      = spike_q;
  assign active_idx = ptr_q;
  assign sweep_done = sweep_q;

endmodule
